clk_div_bank: RTL and testbench

CLK_DIV_BANK -- requirements
Module: clk_div_bank

---
 rtl/clk_div_bank.sv | 148 ++++++++++++++
 tb/tb_clk_div_bank.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH programmable clock dividers with shadowed divisor loads and sync realignment.
// Define CLKDIV_STEP_EN to build the RUN/HALT/STEP control machine (halt/step debug control).
module clk_div_bank #(
   parameter int unsigned      NUM_CH      = 2,
   parameter int unsigned      CNT_W       = 32,
   parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(49)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [2:0]        load_ch,
   input  logic [CNT_W-1:0]  load_div,
   input  logic              sync,
   input  logic              halt,
   input  logic              step,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick,
   output logic              halted
);

   typedef enum logic [1:0] {StRun, StHalt, StStep} state_e;

   state_e state_q, state_d;

   logic [CNT_W-1:0]  cnt_q [NUM_CH];
   logic [CNT_W-1:0]  cnt_d [NUM_CH];
   logic [CNT_W-1:0]  div_q [NUM_CH];
   logic [CNT_W-1:0]  div_d [NUM_CH];
   logic [CNT_W-1:0]  shd_q [NUM_CH];
   logic [CNT_W-1:0]  shd_d [NUM_CH];
   logic [NUM_CH-1:0] pend_q, pend_d;
   logic [NUM_CH-1:0] clk_out_q, clk_out_d;
   logic [NUM_CH-1:0] tick_q, tick_d;
   logic [NUM_CH-1:0] at_end;
   logic [NUM_CH-1:0] load_hit;
   logic [CNT_W:0]    half;
   logic              en;

   assign en = (state_q != StHalt);

   // Per-channel datapath: counter, divisor apply, shadow load, output compare.
   always_comb begin
      half      = '0;
      pend_d    = pend_q;
      clk_out_d = clk_out_q;
      tick_d    = '0;
      at_end    = '0;
      load_hit  = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         cnt_d[i]    = cnt_q[i];
         div_d[i]    = div_q[i];
         shd_d[i]    = shd_q[i];
         at_end[i]   = (cnt_q[i] == div_q[i]);
         load_hit[i] = load && (load_ch == 3'(i));
         half        = ({1'b0, div_q[i]} + {{CNT_W{1'b0}}, 1'b1}) >> 1;

         if (en) begin
            clk_out_d[i] = ({1'b0, cnt_q[i]} < half);
            tick_d[i]    = at_end[i];
         end

         if (sync) begin
            cnt_d[i] = '0;
            if (pend_q[i]) begin
               div_d[i]  = shd_q[i];
               pend_d[i] = 1'b0;
            end
         end else if (en) begin
            if (at_end[i]) begin
               cnt_d[i] = '0;
               if (pend_q[i]) begin
                  div_d[i]  = shd_q[i];
                  pend_d[i] = 1'b0;
               end
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end

         // Applied above from the old shadow; a same-cycle load waits for the next wrap.
         if (load_hit[i]) begin
            shd_d[i] = load_div;
            if (en) begin
               pend_d[i] = 1'b1;
            end
         end
      end
   end

   // Control state machine; sync blocks every transition.
   always_comb begin
      state_d = state_q;
`ifdef CLKDIV_STEP_EN
      if (!sync) begin
         unique case (state_q)
            StRun: begin
               if (halt && at_end[0]) state_d = StHalt;
            end
            StHalt: begin
               if (!halt) begin
                  state_d = StRun;
               end else if (step) begin
                  state_d = StStep;
               end
            end
            StStep: begin
               if (at_end[0]) state_d = halt ? StHalt : StRun;
            end
            default: state_d = StRun;
         endcase
      end
`endif
   end

`ifndef CLKDIV_STEP_EN
   logic unused_ctrl;
   assign unused_ctrl = halt ^ step;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StRun;
         pend_q    <= '0;
         clk_out_q <= '0;
         tick_q    <= '0;
         for (int i = 0; i < int'(NUM_CH); i++) begin
            cnt_q[i] <= '0;
            div_q[i] <= DEFAULT_DIV;
            shd_q[i] <= DEFAULT_DIV;
         end
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         clk_out_q <= clk_out_d;
         tick_q    <= tick_d;
         for (int i = 0; i < int'(NUM_CH); i++) begin
            cnt_q[i] <= cnt_d[i];
            div_q[i] <= div_d[i];
            shd_q[i] <= shd_d[i];
         end
      end
   end

   assign clk_out = clk_out_q;
   assign tick    = tick_q;
   assign halted  = (state_q == StHalt);

endmodule

// File: tb/tb_clk_div_bank.sv
// Randomized bench for clk_div_bank against a period/phase model, plus directed literal checks.
module tb_clk_div_bank;
   localparam int NUM_CH = 2;
   localparam int CNT_W  = 8;
   localparam int DEF    = 3;
   localparam int MRun   = 0;
   localparam int MHalt  = 1;
   localparam int MStep  = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              load = 1'b0;
   logic [2:0]        load_ch = '0;
   logic [CNT_W-1:0]  load_div = '0;
   logic              sync = 1'b0;
   logic              halt = 1'b0;
   logic              step = 1'b0;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] tick;
   logic              halted;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: phase within period, divisor, shadow, pending flag, mode.
   int          m_ph   [NUM_CH];
   int          m_div  [NUM_CH];
   int          m_shd  [NUM_CH];
   bit          m_pend [NUM_CH];
   int          m_mode = MRun;
   bit          m_valid = 1'b0;
   logic [NUM_CH-1:0] e_clk  = '0;
   logic [NUM_CH-1:0] e_tick = '0;
   logic              e_halt = 1'b0;

   logic [0:14] lit_c0 = 15'b110011001100110;
   logic [0:14] lit_t0 = 15'b000100010001000;
   logic [0:14] lit_c1 = 15'b110011111000001;
   logic [0:14] lit_t1 = 15'b000100000000010;
   logic [0:5]  lit_s0 = 6'b110011;
   logic [0:5]  lit_s1 = 6'b111000;

   clk_div_bank #(
      .NUM_CH     (NUM_CH),
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(8'd3)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .load_ch (load_ch),
      .load_div(load_div),
      .sync    (sync),
      .halt    (halt),
      .step    (step),
      .clk_out (clk_out),
      .tick    (tick),
      .halted  (halted)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h at t=%0t", name, act, req, $time);
      end
   endtask

   task automatic model_edge();
      bit run;
      bit wrap0;
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            m_ph[c] = 0; m_div[c] = DEF; m_shd[c] = DEF; m_pend[c] = 1'b0;
         end
         m_mode  = MRun;
         e_clk   = '0;
         e_tick  = '0;
         m_valid = 1'b1;
      end else begin
         run   = (m_mode != MHalt);
         wrap0 = run && (m_ph[0] == m_div[0]);
         for (int c = 0; c < NUM_CH; c++) begin
            e_tick[c] = run && (m_ph[c] == m_div[c]);
            // High for the first floor(period/2) cycles of each period.
            if (run) e_clk[c] = (m_ph[c] < (m_div[c] + 1) / 2);
            if (sync) begin
               m_ph[c] = 0;
               if (m_pend[c]) begin m_div[c] = m_shd[c]; m_pend[c] = 1'b0; end
            end else if (run) begin
               m_ph[c] = (m_ph[c] + 1) % (m_div[c] + 1);
               if (m_ph[c] == 0 && m_pend[c]) begin m_div[c] = m_shd[c]; m_pend[c] = 1'b0; end
            end
         end
         if (load && int'(load_ch) < NUM_CH) begin
            m_shd[load_ch] = int'(load_div);
            if (run) m_pend[load_ch] = 1'b1;
         end
`ifdef CLKDIV_STEP_EN
         if (!sync) begin
            if (m_mode == MRun && halt && wrap0) m_mode = MHalt;
            else if (m_mode == MHalt && !halt) m_mode = MRun;
            else if (m_mode == MHalt && step) m_mode = MStep;
            else if (m_mode == MStep && wrap0) m_mode = halt ? MHalt : MRun;
         end
`else
         if (wrap0) m_mode = MRun;
`endif
      end
      e_halt = (m_mode == MHalt);
   endtask

   initial forever begin
      @(posedge clk);
      model_edge();
   end

   initial forever begin
      @(negedge clk);
      if (m_valid) begin
         check("clk_out", 32'(clk_out), 32'(e_clk));
         check("tick", 32'(tick), 32'(e_tick));
         check("halted", 32'(halted), 32'(e_halt));
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int hcnt;
      // Reset, default pattern, and mid-period load of ch1.
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         check("lit_clk0", 32'(clk_out[0]), 32'(lit_c0[k]));
         check("lit_tick0", 32'(tick[0]), 32'(lit_t0[k]));
         check("lit_clk1", 32'(clk_out[1]), 32'(lit_c1[k]));
         check("lit_tick1", 32'(tick[1]), 32'(lit_t1[k]));
         check("model_clk1", 32'(e_clk[1]), 32'(lit_c1[k]));
         check("model_tick0", 32'(e_tick[0]), 32'(lit_t0[k]));
         if (k == 0) begin load = 1'b1; load_ch = 3'd1; load_div = 8'd9; end
         if (k == 1) load = 1'b0;
      end

      // Sync with ch1 load pending.
      load = 1'b1; load_ch = 3'd1; load_div = 8'd5;
      @(negedge clk);
      load = 1'b0; sync = 1'b1;
      @(negedge clk);
      sync = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("sync_clk0", 32'(clk_out[0]), 32'(lit_s0[k]));
         check("sync_clk1", 32'(clk_out[1]), 32'(lit_s1[k]));
      end

      // Out-of-range load leaves both channels untouched (model covers the cycles after).
      load = 1'b1; load_ch = 3'd5; load_div = 8'd0;
      @(negedge clk);
      load = 1'b0;

      // Fresh reset, then halt/step behaviour.
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_clk", 32'(clk_out), 32'd0);
      rst_n = 1'b1;
      halt  = 1'b1;
`ifdef CLKDIV_STEP_EN
      hcnt = 0;
      while (!halted && hcnt < 30) begin @(negedge clk); hcnt++; end
      check("halt_entry", 32'(halted), 32'd1);
      @(negedge clk);
      cnt = 0;
      for (int k = 0; k < 20; k++) begin @(negedge clk); cnt += int'(tick[0]); end
      check("halt_no_ticks", 32'(cnt), 32'd0);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      cnt = 0;
      for (int k = 0; k < 12; k++) begin @(negedge clk); cnt += int'(tick[0]); end
      check("step_one_tick", 32'(cnt), 32'd1);
      check("step_rehalt", 32'(halted), 32'd1);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_step_clk", 32'(clk_out), 32'd0);
      check("rst_step_tick", 32'(tick), 32'd0);
      check("rst_step_halted", 32'(halted), 32'd0);
      rst_n = 1'b1;
      halt  = 1'b0;
`else
      cnt  = 0;
      hcnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         cnt  += int'(tick[0]);
         hcnt += int'(halted);
      end
      check("nostep_ticks", 32'(cnt), 32'd5);
      check("nostep_halted", 32'(hcnt), 32'd0);
      halt = 1'b0;
`endif

      // Randomized traffic.
      for (int k = 0; k < 4000; k++) begin
         @(negedge clk);
         rst_n    = ($urandom_range(0, 399) != 0);
         load     = ($urandom_range(0, 5) == 0);
         load_ch  = 3'($urandom_range(0, 7));
         load_div = 8'($urandom_range(0, 12));
         sync     = ($urandom_range(0, 39) == 0);
         step     = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 24) == 0) halt = ~halt;
      end
      @(negedge clk);
      load = 1'b0; sync = 1'b0; step = 1'b0; halt = 1'b0; rst_n = 1'b1;
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
